uart_alu_sequencer: RTL and testbench

Sequencer between the UART receiver/transmitter and the combinational ALU. It collects three received bytes in order: operand A, operand B, then the opcode. It holds them stable on the ALU inputs, captures the ALU result one cycle later and sends it back through the UART transmitter with a start/done handshake. A watchdog aborts a partially received command. Overrun and timeout events are flagged as single-cycle pulses.

---
 rtl/uart_alu_sequencer.sv | 158 +++++++++++++++
 tb/tb_uart_alu_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_sequencer.sv
// UART <-> ALU command sequencer: collects A, B and opcode bytes, holds them
// on the ALU inputs, captures the result and hands it to the UART transmitter.
//
// Ports:
//   i_clock, i_reset    : clock, synchronous active-high reset
//   i_rx_done/i_rx_data : received-byte strobe and byte
//   i_alu_result        : combinational ALU output
//   i_tx_done           : transmitter finished the byte
//   o_data_a/o_data_b   : ALU operands (raw bytes)
//   o_operation         : ALU opcode (low NB_OP bits of the third byte)
//   o_tx_start/o_tx_data: transmit request pulse and registered byte
//   o_busy              : command in execution or transmission
//   o_overrun/o_timeout : single-cycle event pulses
module uart_alu_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int NB_TIMER       = 20
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_overrun,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_EXEC,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    localparam logic [NB_TIMER-1:0] TIMER_LAST =
        NB_TIMER'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [NB_TIMER-1:0]  timer_q, timer_d;
    logic [NB_DATA-1:0]   data_a_q, data_a_d;
    logic [NB_DATA-1:0]   data_b_q, data_b_d;
    logic [NB_OP-1:0]     op_q, op_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_now;

    assign busy_now = (state_q == ST_EXEC) || (state_q == ST_SEND)
                   || (state_q == ST_WAIT_TX);

    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        op_d      = op_q;
        tx_data_d = tx_data_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    data_a_d = i_rx_data;
                    state_d  = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    data_b_d = i_rx_data;
                    state_d  = ST_WAIT_OP;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = ST_WAIT_A;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[NB_OP-1:0];
                    state_d = ST_EXEC;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = ST_WAIT_A;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_EXEC: begin
                tx_data_d = i_alu_result;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = ST_WAIT_A;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
        // A byte arriving mid-execution is dropped, never queued.
        overrun_d  = busy_now && i_rx_done;
        tx_start_d = (state_d == ST_SEND);
        busy_d     = (state_d == ST_EXEC) || (state_d == ST_SEND)
                  || (state_d == ST_WAIT_TX);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_WAIT_A;
            timer_q    <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_data_a    = data_a_q;
    assign o_data_b    = data_b_q;
    assign o_operation = op_q;
    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_busy      = busy_q;
    assign o_overrun   = overrun_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: directed scenarios plus random byte traffic,
// checked by a scoreboard fed from a cycle-level command model.
module tb_uart_alu_sequencer;

    localparam int T = 16;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_data_a;
    logic [7:0] o_data_b;
    logic [5:0] o_operation;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       o_busy;
    logic       o_overrun;
    logic       o_timeout;

    uart_alu_sequencer #(
        .NB_DATA        (8),
        .NB_OP          (6),
        .TIMEOUT_CYCLES (T),
        .NB_TIMER       (5)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_data_a     (o_data_a),
        .o_data_b     (o_data_b),
        .o_operation  (o_operation),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun),
        .o_timeout    (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // ALU stub driven from the DUT operand outputs.
    function automatic logic [7:0] alu_stub(
        logic [7:0] a, logic [7:0] b, logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return a ^ 8'h5A;
        endcase
    endfunction

    assign i_alu_result = alu_stub(o_data_a, o_data_b, o_operation);

    // Reference result in plain signed integer arithmetic.
    function automatic logic [7:0] ref_res(
        logic [7:0] a, logic [7:0] b, logic [5:0] op);
        int sa;
        int sb;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            6'h20:   r = sa + sb;
            6'h22:   r = sa - sb;
            6'h24:   r = int'(a) & int'(b);
            6'h25:   r = int'(a) | int'(b);
            6'h26:   r = int'(a) ^ int'(b);
            6'h27:   r = ~(int'(a) | int'(b));
            default: r = int'(a) ^ 32'h5A;
        endcase
        return r[7:0];
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        int         at;
    } tx_exp_t;

    tx_exp_t tx_q[$];
    int      ovr_q[$];
    int      to_q[$];

    // Command model state.
    int         phase = 0;
    bit         busy_m = 0;
    int         last_acc = 0;
    int         eop_m = 0;
    logic [7:0] a_m = 0;
    logic [7:0] b_m = 0;
    logic [5:0] op_m = 0;
    logic [7:0] res_m = 0;
    logic [7:0] tx_m = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic model_edge(bit rv, logic [7:0] rb, bit tv, int e);
        if (busy_m) begin
            if (e == eop_m + 1) tx_m = res_m;
            if (rv) ovr_q.push_back(e);
            if (tv && e >= eop_m + 3) busy_m = 0;
        end else if (rv) begin
            last_acc = e;
            if (phase == 0) begin
                a_m = rb;
                phase = 1;
            end else if (phase == 1) begin
                b_m = rb;
                phase = 2;
            end else begin
                tx_exp_t x;
                op_m  = rb[5:0];
                res_m = ref_res(a_m, b_m, op_m);
                x.a = a_m;
                x.b = b_m;
                x.op = op_m;
                x.res = res_m;
                x.at = e + 1;
                tx_q.push_back(x);
                busy_m = 1;
                eop_m = e;
                phase = 0;
            end
        end else if (phase != 0 && e - last_acc == T) begin
            to_q.push_back(e);
            phase = 0;
        end
    endtask

    task automatic step(bit rv, logic [7:0] rb, bit tv);
        i_rx_done = rv;
        i_rx_data = rb;
        i_tx_done = tv;
        tick();
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        model_edge(rv, rb, tv, cyc);
        chk("busy", 32'(o_busy), 32'(busy_m));
        chk("data_a", 32'(o_data_a), 32'(a_m));
        chk("data_b", 32'(o_data_b), 32'(b_m));
        chk("operation", 32'(o_operation), 32'(op_m));
        chk("tx_data", 32'(o_tx_data), 32'(tx_m));
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_a"}, 32'(o_data_a), 0);
        chk({tag, "_b"}, 32'(o_data_b), 0);
        chk({tag, "_op"}, 32'(o_operation), 0);
        chk({tag, "_start"}, 32'(o_tx_start), 0);
        chk({tag, "_txd"}, 32'(o_tx_data), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_ovr"}, 32'(o_overrun), 0);
        chk({tag, "_to"}, 32'(o_timeout), 0);
    endtask

    task automatic do_reset(string tag);
        int r;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        r = cyc;
        phase = 0;
        busy_m = 0;
        a_m = 0;
        b_m = 0;
        op_m = 0;
        tx_m = 0;
        while (tx_q.size() > 0 && tx_q[tx_q.size()-1].at >= r)
            void'(tx_q.pop_back());
        while (ovr_q.size() > 0 && ovr_q[ovr_q.size()-1] >= r)
            void'(ovr_q.pop_back());
        while (to_q.size() > 0 && to_q[to_q.size()-1] >= r)
            void'(to_q.pop_back());
        check_zero(tag);
    endtask

    task automatic finish_tx();
        repeat (3) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
    endtask

    // Scoreboard monitor: pops an expectation for every output pulse.
    always @(negedge i_clock) begin
        if (!i_reset) begin
            if (tx_q.size() > 0 && tx_q[0].at < cyc) begin
                chk("tx_start_missing", 0, 1);
                void'(tx_q.pop_front());
            end
            if (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
                chk("overrun_missing", 0, 1);
                void'(ovr_q.pop_front());
            end
            if (to_q.size() > 0 && to_q[0] < cyc) begin
                chk("timeout_missing", 0, 1);
                void'(to_q.pop_front());
            end
            if (o_tx_start) begin
                if (tx_q.size() == 0) begin
                    chk("tx_start_unexpected", 1, 0);
                end else begin
                    tx_exp_t x;
                    x = tx_q.pop_front();
                    chk("tx_start_cycle", cyc, x.at);
                    chk("tx_result", 32'(o_tx_data), 32'(x.res));
                    chk("tx_opa", 32'(o_data_a), 32'(x.a));
                    chk("tx_opb", 32'(o_data_b), 32'(x.b));
                    chk("tx_op", 32'(o_operation), 32'(x.op));
                end
            end
            if (o_overrun) begin
                if (ovr_q.size() == 0) chk("overrun_unexpected", 1, 0);
                else chk("overrun_cycle", cyc, ovr_q.pop_front());
            end
            if (o_timeout) begin
                if (to_q.size() == 0) chk("timeout_unexpected", 1, 0);
                else chk("timeout_cycle", cyc, to_q.pop_front());
            end
        end
    end

    initial begin
        tick();
        do_reset("reset");

        // Basic ADD
        step(1'b1, 8'h05, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        chk("add_op", 32'(o_operation), 32'h20);
        step(1'b0, 8'h00, 1'b0);
        chk("add_start", 32'(o_tx_start), 1);
        chk("add_result", 32'(o_tx_data), 32'h08);
        repeat (10) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("add_idle", 32'(o_busy), 0);

        // Signed operands, then an overrun during WAIT_TX
        step(1'b1, 8'hFB, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'hE2, 1'b0);
        chk("sgn_op", 32'(o_operation), 32'h22);
        step(1'b0, 8'h00, 1'b0);
        chk("sgn_start", 32'(o_tx_start), 1);
        chk("sgn_result", 32'(o_tx_data), 32'hF9);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        chk("ovr_pulse", 32'(o_overrun), 1);
        step(1'b0, 8'h00, 1'b0);
        chk("ovr_single", 32'(o_overrun), 0);
        chk("ovr_keep_a", 32'(o_data_a), 32'hFB);
        chk("ovr_busy", 32'(o_busy), 1);
        step(1'b0, 8'h00, 1'b1);

        // Timeout after a lone operand A
        step(1'b1, 8'h11, 1'b0);
        repeat (T - 1) step(1'b0, 8'h00, 1'b0);
        chk("to_early", 32'(o_timeout), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("to_pulse", 32'(o_timeout), 1);
        step(1'b0, 8'h00, 1'b0);
        chk("to_single", 32'(o_timeout), 0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        chk("to_next_a", 32'(o_data_a), 32'h01);
        chk("to_next_b", 32'(o_data_b), 32'h02);
        finish_tx();

        // Byte B lands exactly on the expiry cycle
        step(1'b1, 8'hAA, 1'b0);
        repeat (T - 1) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        chk("race_no_to", 32'(o_timeout), 0);
        chk("race_b", 32'(o_data_b), 32'hBB);
        step(1'b0, 8'h00, 1'b0);
        chk("race_no_to2", 32'(o_timeout), 0);
        step(1'b1, 8'h24, 1'b0);
        finish_tx();

        // Reset in WAIT_OP, then in WAIT_TX
        step(1'b1, 8'h07, 1'b0);
        step(1'b1, 8'h09, 1'b0);
        do_reset("rst_wop");
        step(1'b1, 8'h30, 1'b0);
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'h26, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        do_reset("rst_wtx");
        step(1'b0, 8'h00, 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b0);
        chk("rst_no_start", 32'(o_tx_start), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit         rv;
            bit         tv;
            logic [7:0] rb;
            logic [5:0] ops [6];
            ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
            rv = 1'b0;
            tv = 1'b0;
            rb = 8'($urandom);
            if (busy_m) begin
                tv = ($urandom_range(3) == 0);
                rv = ($urandom_range(7) == 0);
            end else if ($urandom_range(39) == 0) begin
                repeat (20) step(1'b0, 8'h00, 1'b0);
            end else begin
                rv = ($urandom_range(4) == 0);
                if (phase == 2 && $urandom_range(1) == 0)
                    rb = {2'($urandom), ops[$urandom_range(5)]};
            end
            step(rv, rb, tv);
        end

        repeat (4) step(1'b0, 8'h00, 1'b1);
        repeat (T + 4) step(1'b0, 8'h00, 1'b0);
        chk("drain_tx", tx_q.size(), 0);
        chk("drain_ovr", ovr_q.size(), 0);
        chk("drain_to", to_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
